// File: rtl/vga_timing_engine.sv
// VGA timing generator: parametrised porches/sync, pixel-enable strobe, two-stage output pipeline.
// Cursor overlay with frame-synchronised shadow registers is built only when VGA_CURSOR_EN is defined.
module vga_timing_engine #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned CW          = 3,
  parameter int unsigned CURSOR_SIZE = 32
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iEnable,
  input  logic [CW-1:0] iPixelRGB,
  input  logic [9:0]    iCursorX,
  input  logic [9:0]    iCursorY,
  input  logic [CW-1:0] iCursorColor,
  input  logic          iCursorShow,
  output logic [9:0]    oHcounter,
  output logic [9:0]    oVcounter,
  output logic [CW-1:0] oRGB,
  output logic          oHsync,
  output logic          oVsync,
  output logic          oActive,
  output logic          oFrameStart
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned EXT_W   = CNT_W + 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             s1_hsync_q, s1_hsync_d;
  logic             s1_vsync_q, s1_vsync_d;
  logic             s1_active_q, s1_active_d;
  logic             s1_fs_q, s1_fs_d;
  logic [CW-1:0]    rgb_d;
  logic             hsync_d, vsync_d;

  assign oHcounter = hcnt_q;
  assign oVcounter = vcnt_q;

  // Raster counters; advance is gated by iEnable in the register block
  always_comb begin
    hcnt_d = hcnt_q + CNT_W'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
    end
  end

  // Stage 1: decode the current counter position
  always_comb begin
    s1_hsync_d  = (hcnt_q >= H_SS) && (hcnt_q <= H_SE);
    s1_vsync_d  = (vcnt_q >= V_SS) && (vcnt_q <= V_SE);
    s1_active_d = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    s1_fs_d     = (hcnt_q == '0) && (vcnt_q == '0);
  end

`ifdef VGA_CURSOR_EN
  logic [CNT_W-1:0] shd_x_q, shd_y_q;
  logic [CW-1:0]    shd_color_q;
  logic             shd_show_q;
  logic             shd_load_c;
  logic [EXT_W-1:0] x_hi_c, y_hi_c;
  logic             s1_hit_q, s1_hit_d;

  // Shadow copy is refreshed only at the first blanking line so a frame never tears
  assign shd_load_c = (hcnt_q == '0) && (vcnt_q == V_ACT);
  assign x_hi_c     = {1'b0, shd_x_q} + EXT_W'(CURSOR_SIZE - 1);
  assign y_hi_c     = {1'b0, shd_y_q} + EXT_W'(CURSOR_SIZE - 1);
  assign s1_hit_d   = shd_show_q
                    && ({1'b0, hcnt_q} >= {1'b0, shd_x_q}) && ({1'b0, hcnt_q} <= x_hi_c)
                    && ({1'b0, vcnt_q} >= {1'b0, shd_y_q}) && ({1'b0, vcnt_q} <= y_hi_c);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shd_x_q     <= '0;
      shd_y_q     <= '0;
      shd_color_q <= '0;
      shd_show_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
    end else if (iEnable) begin
      if (shd_load_c) begin
        shd_x_q     <= iCursorX;
        shd_y_q     <= iCursorY;
        shd_color_q <= iCursorColor;
        shd_show_q  <= iCursorShow;
      end
      s1_hit_q <= s1_hit_d;
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{iCursorX, iCursorY, iCursorColor, iCursorShow};
`endif

  // Stage 2: pixel mux and sync polarity
  always_comb begin
    rgb_d = '0;
    if (s1_active_q) begin
      rgb_d = iPixelRGB;
`ifdef VGA_CURSOR_EN
      if (s1_hit_q) rgb_d = shd_color_q;
`endif
    end
    hsync_d = s1_hsync_q ? SYNC_POL : ~SYNC_POL;
    vsync_d = s1_vsync_q ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      s1_hsync_q  <= 1'b0;
      s1_vsync_q  <= 1'b0;
      s1_active_q <= 1'b0;
      s1_fs_q     <= 1'b0;
      oRGB        <= '0;
      oHsync      <= ~SYNC_POL;
      oVsync      <= ~SYNC_POL;
      oActive     <= 1'b0;
      oFrameStart <= 1'b0;
    end else if (iEnable) begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      s1_hsync_q  <= s1_hsync_d;
      s1_vsync_q  <= s1_vsync_d;
      s1_active_q <= s1_active_d;
      s1_fs_q     <= s1_fs_d;
      oRGB        <= rgb_d;
      oHsync      <= hsync_d;
      oVsync      <= vsync_d;
      oActive     <= s1_active_q;
      oFrameStart <= s1_fs_q;
    end
  end

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench for vga_timing_engine on a reduced 80x55 raster (64x48 visible, 8x8 cursor).
module tb_vga_timing_engine;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CW = 3;
  localparam int CS = 8;
  localparam int LIMIT = 100000;
  localparam logic [CW-1:0] CCOL = 3'b100;
`ifdef VGA_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic          Clock, Reset, iEnable, iCursorShow;
  logic [CW-1:0] iPixelRGB, iCursorColor, oRGB;
  logic [9:0]    iCursorX, iCursorY, oHcounter, oVcounter;
  logic          oHsync, oVsync, oActive, oFrameStart;

  vga_timing_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CW(CW), .CURSOR_SIZE(CS)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iPixelRGB(iPixelRGB),
    .iCursorX(iCursorX), .iCursorY(iCursorY), .iCursorColor(iCursorColor),
    .iCursorShow(iCursorShow), .oHcounter(oHcounter), .oVcounter(oVcounter),
    .oRGB(oRGB), .oHsync(oHsync), .oVsync(oVsync), .oActive(oActive),
    .oFrameStart(oFrameStart)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_tests = 0, n_fail = 0;
  int m_h, m_v, m_frame, p1h, p1v, p2h, p2v;
  bit pv1, pv2;
  int sx, sy;
  logic [CW-1:0] scol;
  bit sshow;
  int e_rgb, e_sync, e_act, e_fs, e_cnt, e_hold;
  int sys_cyc, en_cyc, h0_cyc, hs_fall, hs_w, hs_off, vs_fall, vs_w;
  int fs_last_en, fs_last_sys, fs_sp_en, fs_sp_sys;
  bit hs_armed, vs_armed, fs_armed;
  int pr_h [9] = '{10, 17, 18, 10, 30, 62, 0, 64, 63};
  int pr_v [9] = '{16, 22, 16, 23, 16, 30, 31, 30, 37};
  logic [CW-1:0] pr_o [9];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] pix(input int h, input int v);
    return CW'(h + 2 * v + 1);
  endfunction

  function automatic logic [CW-1:0] curs(input logic [CW-1:0] p);
    return CUR_EN ? CCOL : p;
  endfunction

  function automatic logic [CW-1:0] exp_rgb(input int h, input int v);
    if (h >= HA || v >= VA) return '0;
    if (CUR_EN && sshow && h >= sx && h <= sx + CS - 1 && v >= sy && v <= sy + CS - 1)
      return scol;
    return pix(h, v);
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_frame = 0; pv1 = 0; pv2 = 0;
    sx = 0; sy = 0; scol = '0; sshow = 0;
  endtask

  task automatic clear_meas();
    e_rgb = 0; e_sync = 0; e_act = 0; e_fs = 0; e_cnt = 0; e_hold = 0;
    hs_w = 0; hs_off = 0; vs_w = 0; fs_sp_en = 0; fs_sp_sys = 0; h0_cyc = 0;
    hs_armed = 0; vs_armed = 0; fs_armed = 0;
  endtask

  // One system clock: drive enable, advance the model, compare pins against the model
  task automatic step(input bit en);
    logic [CW-1:0] prgb;
    logic phs, pvs, pact, pfs;
    logic [9:0] ph, pv;
    logic [CW-1:0] er;
    bit ehs, evs, eact, efs;
    @(negedge Clock);
    iEnable = en;
    prgb = oRGB; phs = oHsync; pvs = oVsync; pact = oActive; pfs = oFrameStart;
    ph = oHcounter; pv = oVcounter;
    @(posedge Clock);
    #1;
    sys_cyc++;
    if (en) begin
      en_cyc++;
      if (m_h == 0 && m_v == VA) begin
        sx = iCursorX; sy = iCursorY; scol = iCursorColor; sshow = iCursorShow;
      end
      p2h = p1h; p2v = p1v; pv2 = pv1;
      p1h = m_h; p1v = m_v; pv1 = 1;
      if (m_h == HT - 1) begin
        m_h = 0;
        if (m_v == VT - 1) begin m_v = 0; m_frame++; end
        else m_v++;
      end else m_h++;
      iPixelRGB = pix(p1h, p1v);
    end
    if (pv2) begin
      er   = exp_rgb(p2h, p2v);
      ehs  = !(p2h >= HA + HF && p2h <= HA + HF + HS - 1);
      evs  = !(p2v >= VA + VF && p2v <= VA + VF + VS - 1);
      eact = (p2h < HA) && (p2v < VA);
      efs  = (p2h == 0) && (p2v == 0);
      for (int i = 0; i < 9; i++)
        if (p2h == pr_h[i] && p2v == pr_v[i]) pr_o[i] = oRGB;
    end else begin
      er = '0; ehs = 1; evs = 1; eact = 0; efs = 0;
    end
    if (oRGB !== er) e_rgb++;
    if (oHsync !== ehs || oVsync !== evs) e_sync++;
    if (oActive !== eact) e_act++;
    if (oFrameStart !== efs) e_fs++;
    if (oHcounter !== 10'(m_h) || oVcounter !== 10'(m_v)) e_cnt++;
    if (!en && (oRGB !== prgb || oHsync !== phs || oVsync !== pvs || oActive !== pact ||
                oFrameStart !== pfs || oHcounter !== ph || oVcounter !== pv)) e_hold++;
    if (oHcounter == 10'd0 && ph != 10'd0) h0_cyc = sys_cyc;
    if (phs && !oHsync) begin hs_fall = sys_cyc; hs_off = sys_cyc - h0_cyc; hs_armed = 1; end
    if (!phs && oHsync && hs_armed) hs_w = sys_cyc - hs_fall;
    if (pvs && !oVsync) begin vs_fall = sys_cyc; vs_armed = 1; end
    if (!pvs && oVsync && vs_armed) vs_w = sys_cyc - vs_fall;
    if (!pfs && oFrameStart) begin
      if (fs_armed) begin
        fs_sp_en = en_cyc - fs_last_en;
        fs_sp_sys = sys_cyc - fs_last_sys;
      end
      fs_last_en = en_cyc; fs_last_sys = sys_cyc; fs_armed = 1;
    end
  endtask

  // Step until the model counter reaches (0, v) of frame f, one strobe per period clocks
  task automatic run_to(input int f, input int v, input int period);
    int iter;
    iter = 0;
    while (!(m_frame == f && m_v == v && m_h == 0) && iter < LIMIT) begin
      step(1'b1);
      for (int k = 1; k < period; k++) step(1'b0);
      iter++;
    end
    if (iter >= LIMIT) check_eq("run_to_bound", iter, 0);
  endtask

  task automatic check_aggr(input string ph);
    check_eq({ph, "_rgb_errs"}, e_rgb, 0);
    check_eq({ph, "_sync_errs"}, e_sync, 0);
    check_eq({ph, "_active_errs"}, e_act, 0);
    check_eq({ph, "_fs_errs"}, e_fs, 0);
    check_eq({ph, "_counter_errs"}, e_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; iEnable = 1'b0; iPixelRGB = '0;
    iCursorX = 10'd10; iCursorY = 10'd15; iCursorColor = CCOL; iCursorShow = 1'b1;
    sys_cyc = 0; en_cyc = 0; p1h = 0; p1v = 0; p2h = 0; p2v = 0;
    for (int i = 0; i < 9; i++) pr_o[i] = '0;
    model_reset();
    clear_meas();
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (30) step(1'b1);

    // Reset mid-line: outputs must clear asynchronously
    @(negedge Clock);
    iEnable = 1'b0;
    Reset = 1'b1;
    #1;
    check_eq("rst_hcnt", oHcounter, 0);
    check_eq("rst_vcnt", oVcounter, 0);
    check_eq("rst_rgb", oRGB, 0);
    check_eq("rst_active", oActive, 0);
    check_eq("rst_fs", oFrameStart, 0);
    check_eq("rst_hsync", oHsync, 1);
    check_eq("rst_vsync", oVsync, 1);
    model_reset();
    clear_meas();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    step(1'b1);
    check_eq("fs_after_1st", oFrameStart, 0);
    step(1'b1);
    check_eq("fs_after_2nd", oFrameStart, 1);
    check_eq("active_px00", oActive, 1);
    check_eq("rgb_px00", oRGB, pix(0, 0));
    check_eq("hcnt_after_2", oHcounter, 2);
    step(1'b1);
    check_eq("fs_after_3rd", oFrameStart, 0);

    run_to(1, 0, 1);
    check_eq("hsync_width", hs_w, 8);
    check_eq("hsync_fall_offset", hs_off, 70);
    check_eq("vsync_width", vs_w, 160);
    check_eq("f0_no_cursor_p0", pr_o[0], pix(10, 16));
    check_eq("f0_no_cursor_p1", pr_o[1], pix(17, 22));

    run_to(2, 10, 1);
    check_eq("frame_spacing_en", fs_sp_en, HT * VT);
    check_eq("f1_cur_topleft", pr_o[0], curs(pix(10, 16)));
    check_eq("f1_cur_botright", pr_o[1], curs(pix(17, 22)));
    check_eq("f1_right_of_cur", pr_o[2], pix(18, 16));
    check_eq("f1_below_cur", pr_o[3], pix(10, 23));
    check_eq("f1_x30_not_cur", pr_o[4], pix(30, 16));
    check_eq("f1_blank_zero", pr_o[7], 0);

    iCursorX = 10'd30;
    run_to(3, 10, 1);
    check_eq("f2_still_x10", pr_o[0], curs(pix(10, 16)));
    check_eq("f2_x30_not_yet", pr_o[4], pix(30, 16));

    iCursorX = 10'd60; iCursorY = 10'd30;
    run_to(4, 10, 1);
    check_eq("f3_x10_gone", pr_o[0], pix(10, 16));
    check_eq("f3_x30_shown", pr_o[4], curs(pix(30, 16)));

    run_to(5, 0, 1);
    check_eq("f4_edge_col62", pr_o[5], curs(pix(62, 30)));
    check_eq("f4_edge_col63", pr_o[8], curs(pix(63, 37)));
    check_eq("f4_no_wrap_col0", pr_o[6], pix(0, 31));
    check_eq("f4_clip_col64", pr_o[7], 0);
    check_aggr("full_rate");

    // One strobe in four: every interval stretches by four and pins hold between strobes
    clear_meas();
    run_to(6, 1, 4);
    check_eq("slow_hsync_width", hs_w, 32);
    check_eq("slow_hsync_fall_offset", hs_off, 280);
    check_eq("slow_vsync_width", vs_w, 640);
    check_eq("slow_frame_spacing_en", fs_sp_en, HT * VT);
    check_eq("slow_frame_spacing_sys", fs_sp_sys, 4 * HT * VT);
    check_eq("slow_hold_errs", e_hold, 0);
    check_aggr("quarter_rate");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_engine.md
# vga_timing_engine

Parametrised VGA timing generator with a movable, frame-synchronised cursor overlay. It replaces the fixed 800x525 controller in the VGA path. It generates sync, blanking and pixel coordinates from arbitrary porch/sync parameters, and runs from a fast clock via a pixel-enable. It outputs RGB aligned with sync through a fixed two-stage pipeline. The upstream pixel source (frame RAM) is addressed by the coordinate outputs; the PS2 keyboard logic drives the cursor inputs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- CW, 3, colour width
- CURSOR_SIZE, 32, cursor edge length (pixels)

Ports:
- Clock  in  1  system clock
- Reset  in  1  reset, asynchronous, active-high
- iEnable  in  1  pixel strobe; the block advances only on cycles with iEnable=1
- iPixelRGB  in  CW  pixel for the coordinates presented one enabled cycle earlier
- iCursorX, iCursorY  in  10  cursor top-left, in active-area coordinates
- iCursorColor  in  CW  cursor fill colour
- iCursorShow  in  1  cursor visible
- oHcounter, oVcounter  out  10  current raw counters (pixel-source address)
- oRGB  out  CW  pixel to DAC
- oHsync, oVsync  out  1  sync outputs
- oActive  out  1  oRGB lies in the visible area
- oFrameStart  out  1  one-enabled-cycle pulse, aligned with pixel (0,0) at the pins

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is defined the same way (default 525). All counters are 10 bits, and both totals must be ≤1024.
- On an enabled cycle, hcnt increments. At H_TOTAL-1, hcnt wraps to 0 and vcnt increments. vcnt wraps to 0 when vcnt reaches V_TOTAL-1 and hcnt reaches H_TOTAL-1.
- Hsync is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Vsync uses the same rule with the V parameters.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE. Outside it, oRGB=0.
- Shadow cursor registers (X, Y, colour, show) are loaded only on the enabled cycle where hcnt=0 and vcnt=V_ACTIVE, which is the start of vertical blanking. A mid-frame input change is never visible until the next frame.
- Cursor hit: X≤hcnt≤X+CURSOR_SIZE-1 and Y≤vcnt≤Y+CURSOR_SIZE-1, with the comparison done in 11-bit arithmetic so nothing wraps. The part of the cursor past the active edge is clipped by the active test.
- Within the active region, a cursor hit with show=1 outputs the shadow colour. Otherwise oRGB=iPixelRGB.

## Timing
- Stage 1 registers sync, active, cursor-hit and frame-start from the counters.
- Stage 2 registers oRGB, oHsync, oVsync, oActive and oFrameStart.
- Latency from counter value to pins is 2 enabled cycles, identical for every output. iPixelRGB is sampled by stage 2, so it must be valid one enabled cycle after its address appears.
- On iEnable=0, all registers hold, including the pipeline.
- Reset values:
  - counters 0, oRGB 0, oActive 0, oFrameStart 0
  - oHsync = oVsync = ~SYNC_POL
  - shadow show = 0, X = Y = 0, colour 0
- Reset mid-frame behaves as above. The first oFrameStart after reset release comes 2 enabled cycles after release.
- Frame period is H_TOTAL×V_TOTAL enabled cycles (default 420000).

## Configuration
- VGA_CURSOR_EN defined: shadow registers and overlay logic are present as described.
- VGA_CURSOR_EN undefined: no cursor logic and no shadow registers. Cursor inputs are ignored, and oRGB is iPixelRGB in the active region and 0 elsewhere. Sync and latency are unchanged.

## Test plan
- Reset asserted mid-line, default params → all outputs at reset values immediately. After release, oFrameStart pulses on the 2nd enabled cycle, and later oFrameStart pulses are spaced exactly 420000 enabled cycles apart.
- Default params, iEnable=1 → oHsync low for exactly 96 cycles, with the falling edge 658 cycles after hcnt=0 (counter 656 plus 2-cycle latency). oVsync is low for exactly 1600 cycles.
- iEnable toggling 1-of-4 → all timing stretches ×4, and outputs hold between strobes.
- Cursor X=100, Y=50, colour 3'b100, show=1, loaded before blanking → next frame shows 100 on pixels (100..131, 50..81), iPixelRGB elsewhere, and 0 in blanking.
- Cursor X changed to 200 at vcnt=10 → the current frame still shows X=100; the next frame shows X=200.
- X=630 → only columns 630..639 are coloured, with no wrap into column 0 of the next line. Rebuild without VGA_CURSOR_EN → no override anywhere.
